sc_level_sequencer: RTL and testbench

Game-level controller that sequences the bank of per-row background-type registers. It turns frog events (arrived at the far bank, died) and a start request into 2-bit row commands: 00 hold, 01 load the level pattern, 10 restore the init pattern. Each command is swept row by row across the register bank. It also tracks the current level and the remaining lives, and sits between the game-event logic and the row registers.

---
 rtl/sc_levelseq_pkg.sv | 20 ++
 rtl/sc_levelseq_rowsweep.sv | 49 ++++
 rtl/sc_level_sequencer.sv | 148 ++++++++++++++
 tb/tb_sc_level_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sc_levelseq_pkg.sv
// sc_levelseq_pkg
// Shared types and constants for the game-level sequencer slice.
//   levelState_t : FSM states of sc_level_sequencer
//   CMD_*        : 2-bit row commands sent to the background-type registers
package sc_levelseq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    PLAY  = 3'd3,
    OVER  = 3'd4,
    WIN   = 3'd5
  } levelState_t;

  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_LOAD = 2'b01;
  localparam logic [1:0] CMD_INIT = 2'b10;

endpackage

// File: rtl/sc_levelseq_rowsweep.sv
// sc_levelseq_rowsweep
// Row counter that walks 0..ROWS-1, one row per clock, after a start pulse.
// Ports:
//   SC_RowSweep_CLOCK_50      in   clock
//   SC_RowSweep_RESET_InLow   in   async active-low reset
//   SC_RowSweep_START_InHigh  in   begin a sweep at row 0 on the next cycle
//   SC_RowSweep_ROWSEL_OutBUS out  current row index
//   SC_RowSweep_ACTIVE_OutHigh out a sweep is in progress
//   SC_RowSweep_DONE_OutHigh  out  high during the last row of a sweep
// A start pulse coinciding with DONE restarts at row 0 without a gap, which
// is what lets two sweeps run back-to-back.
module sc_levelseq_rowsweep #(
  parameter int ROWS = 14
) (
  input  logic       SC_RowSweep_CLOCK_50,
  input  logic       SC_RowSweep_RESET_InLow,
  input  logic       SC_RowSweep_START_InHigh,
  output logic [3:0] SC_RowSweep_ROWSEL_OutBUS,
  output logic       SC_RowSweep_ACTIVE_OutHigh,
  output logic       SC_RowSweep_DONE_OutHigh
);

  localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

  logic [3:0] rowSel;
  logic       sweepActive;

  assign SC_RowSweep_DONE_OutHigh   = sweepActive && (rowSel == LAST_ROW);
  assign SC_RowSweep_ROWSEL_OutBUS  = rowSel;
  assign SC_RowSweep_ACTIVE_OutHigh = sweepActive;

  always_ff @(posedge SC_RowSweep_CLOCK_50 or negedge SC_RowSweep_RESET_InLow) begin
    if (!SC_RowSweep_RESET_InLow) begin
      rowSel      <= 4'd0;
      sweepActive <= 1'b0;
    end else if (SC_RowSweep_START_InHigh) begin
      rowSel      <= 4'd0;
      sweepActive <= 1'b1;
    end else if (sweepActive) begin
      if (rowSel == LAST_ROW) begin
        rowSel      <= 4'd0;
        sweepActive <= 1'b0;
      end else begin
        rowSel <= rowSel + 4'd1;
      end
    end
  end

endmodule

// File: rtl/sc_level_sequencer.sv
// sc_level_sequencer
// Game-level controller: turns START / ARRIVED / DIED pulses into row-by-row
// sweeps of the background-type register bank and tracks level and lives.
// Ports:
//   SC_LevelSeq_CLOCK_50          in   clock
//   SC_LevelSeq_RESET_InLow       in   async active-low reset
//   SC_LevelSeq_START_InHigh      in   start / restart pulse
//   SC_LevelSeq_ARRIVED_InHigh    in   frog reached the goal pulse
//   SC_LevelSeq_DIED_InHigh       in   frog lost a life pulse
//   SC_LevelSeq_CMD_OutBUS        out  row command (00 hold, 01 load, 10 init)
//   SC_LevelSeq_ROWSEL_OutBUS     out  row addressed by CMD
//   SC_LevelSeq_LEVEL_OutBUS      out  current level
//   SC_LevelSeq_LIVES_OutBUS      out  lives remaining
//   SC_LevelSeq_BUSY_OutHigh      out  sweep in progress
//   SC_LevelSeq_GAMEOVER_OutHigh  out  lives exhausted
//   SC_LevelSeq_WIN_OutHigh       out  final level cleared
// Build option: SC_LEVELSEQ_WRAP_EN -- ARRIVED at LEVEL_MAX wraps to level 0
// with a LOAD sweep instead of entering WIN.
// Event inputs are single-cycle pulses with no handshake: a pulse is acted on
// only if the FSM is in a state that accepts it in that cycle, otherwise it is
// dropped. The FSM state register `state` is the debug point for checkers.
module sc_level_sequencer
  import sc_levelseq_pkg::*;
#(
  parameter int ROWS       = 14,
  parameter int LEVEL_MAX  = 3,
  parameter int LIVES_INIT = 3
) (
  input  logic       SC_LevelSeq_CLOCK_50,
  input  logic       SC_LevelSeq_RESET_InLow,
  input  logic       SC_LevelSeq_START_InHigh,
  input  logic       SC_LevelSeq_ARRIVED_InHigh,
  input  logic       SC_LevelSeq_DIED_InHigh,
  output logic [1:0] SC_LevelSeq_CMD_OutBUS,
  output logic [3:0] SC_LevelSeq_ROWSEL_OutBUS,
  output logic [3:0] SC_LevelSeq_LEVEL_OutBUS,
  output logic [1:0] SC_LevelSeq_LIVES_OutBUS,
  output logic       SC_LevelSeq_BUSY_OutHigh,
  output logic       SC_LevelSeq_GAMEOVER_OutHigh,
  output logic       SC_LevelSeq_WIN_OutHigh
);

  localparam logic [3:0] LEVEL_TOP  = 4'(LEVEL_MAX);
  localparam logic [1:0] LIVES_FULL = 2'(LIVES_INIT);

  levelState_t state, stateNext;
  logic [3:0]  levelQ, levelNext;
  logic [1:0]  livesQ, livesNext;
  logic        sweepStart, sweepActive, sweepDone;
  logic [3:0]  rowSel;

  sc_levelseq_rowsweep #(.ROWS(ROWS)) uRowSweep (
    .SC_RowSweep_CLOCK_50      (SC_LevelSeq_CLOCK_50),
    .SC_RowSweep_RESET_InLow   (SC_LevelSeq_RESET_InLow),
    .SC_RowSweep_START_InHigh  (sweepStart),
    .SC_RowSweep_ROWSEL_OutBUS (rowSel),
    .SC_RowSweep_ACTIVE_OutHigh(sweepActive),
    .SC_RowSweep_DONE_OutHigh  (sweepDone)
  );

  always_ff @(posedge SC_LevelSeq_CLOCK_50 or negedge SC_LevelSeq_RESET_InLow) begin
    if (!SC_LevelSeq_RESET_InLow) begin
      state  <= IDLE;
      levelQ <= 4'd0;
      livesQ <= LIVES_FULL;
    end else begin
      state  <= stateNext;
      levelQ <= levelNext;
      livesQ <= livesNext;
    end
  end

  always_comb begin
    stateNext  = state;
    levelNext  = levelQ;
    livesNext  = livesQ;
    sweepStart = 1'b0;
    unique case (state)
      IDLE, OVER, WIN: begin
        if (SC_LevelSeq_START_InHigh) begin
          levelNext  = 4'd0;
          livesNext  = LIVES_FULL;
          stateNext  = CLEAR;
          sweepStart = 1'b1;
        end
      end
      CLEAR: begin
        // A CLEAR sweep either follows a start (lives full -> LOAD) or the
        // last death (lives 0 -> OVER); the lives count tells them apart.
        if (sweepDone) begin
          if (livesQ == 2'd0) begin
            stateNext = OVER;
          end else begin
            stateNext  = LOAD;
            sweepStart = 1'b1;
          end
        end
      end
      LOAD: begin
        if (sweepDone) stateNext = PLAY;
      end
      PLAY: begin
        if (SC_LevelSeq_START_InHigh) begin
          levelNext  = 4'd0;
          livesNext  = LIVES_FULL;
          stateNext  = CLEAR;
          sweepStart = 1'b1;
        end else if (SC_LevelSeq_DIED_InHigh) begin
          // DIED outranks a simultaneous ARRIVED.
          if (livesQ != 2'd0) livesNext = livesQ - 2'd1;
          stateNext  = (livesQ <= 2'd1) ? CLEAR : LOAD;
          sweepStart = 1'b1;
        end else if (SC_LevelSeq_ARRIVED_InHigh) begin
          if (levelQ < LEVEL_TOP) begin
            levelNext  = levelQ + 4'd1;
            stateNext  = LOAD;
            sweepStart = 1'b1;
          end else begin
`ifdef SC_LEVELSEQ_WRAP_EN
            levelNext  = 4'd0;
            stateNext  = LOAD;
            sweepStart = 1'b1;
`else
            stateNext  = WIN;
`endif
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    SC_LevelSeq_CMD_OutBUS = CMD_HOLD;
    if (sweepActive) begin
      if (state == CLEAR)     SC_LevelSeq_CMD_OutBUS = CMD_INIT;
      else if (state == LOAD) SC_LevelSeq_CMD_OutBUS = CMD_LOAD;
    end
  end

  assign SC_LevelSeq_ROWSEL_OutBUS    = rowSel;
  assign SC_LevelSeq_LEVEL_OutBUS     = levelQ;
  assign SC_LevelSeq_LIVES_OutBUS     = livesQ;
  assign SC_LevelSeq_BUSY_OutHigh     = sweepActive;
  assign SC_LevelSeq_GAMEOVER_OutHigh = (state == OVER);
  assign SC_LevelSeq_WIN_OutHigh      = (state == WIN);

endmodule

// File: tb/tb_sc_level_sequencer.sv
// tb_sc_level_sequencer
// Directed, table-driven bench for sc_level_sequencer (default parameters).
// Each table record is one clock cycle: the outputs expected during that
// cycle, and the input pulses presented for the following rising edge.
// Honours SC_LEVELSEQ_WRAP_EN the same way the design does.
module tb_sc_level_sequencer;
  import sc_levelseq_pkg::*;

  localparam int N_ROWS = 14;
  localparam int OUT_W  = 15;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_p = 1'b0, arrived_p = 1'b0, died_p = 1'b0;
  logic [1:0] cmd;
  logic [3:0] rowsel, level;
  logic [1:0] lives;
  logic       busy, gameover, win;

  always #5 clk = ~clk;

  sc_level_sequencer dut (
    .SC_LevelSeq_CLOCK_50        (clk),
    .SC_LevelSeq_RESET_InLow     (rst_n),
    .SC_LevelSeq_START_InHigh    (start_p),
    .SC_LevelSeq_ARRIVED_InHigh  (arrived_p),
    .SC_LevelSeq_DIED_InHigh     (died_p),
    .SC_LevelSeq_CMD_OutBUS      (cmd),
    .SC_LevelSeq_ROWSEL_OutBUS   (rowsel),
    .SC_LevelSeq_LEVEL_OutBUS    (level),
    .SC_LevelSeq_LIVES_OutBUS    (lives),
    .SC_LevelSeq_BUSY_OutHigh    (busy),
    .SC_LevelSeq_GAMEOVER_OutHigh(gameover),
    .SC_LevelSeq_WIN_OutHigh     (win)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic             start;
    logic             arrived;
    logic             died;
    logic [OUT_W-1:0] exp;
  } vec_t;

  vec_t vecs[$];
  logic [OUT_W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [OUT_W-1:0] pack_exp(logic [1:0] c, logic [3:0] rs, logic [3:0] lvl,
                                                logic [1:0] lv, logic b, logic g, logic w);
    return {c, rs, lvl, lv, b, g, w};
  endfunction

  function automatic void add(logic s, logic a, logic d, logic [1:0] c, logic [3:0] rs,
                              logic [3:0] lvl, logic [1:0] lv, logic b, logic g, logic w);
    vec_t v;
    v.start = s; v.arrived = a; v.died = d;
    v.exp = pack_exp(c, rs, lvl, lv, b, g, w);
    vecs.push_back(v);
  endfunction

  // One sweep: rows 0..nrows-1 with CMD=code and BUSY=1. An ARRIVED pulse
  // can be injected at row arr_at to show it is ignored mid-sweep.
  function automatic void add_sweep(logic [1:0] code, logic [3:0] lvl, logic [1:0] lv,
                                    int arr_at, int nrows);
    for (int r = 0; r < nrows; r++)
      add(1'b0, (r == arr_at), 1'b0, code, 4'(r), lvl, lv, 1'b1, 1'b0, 1'b0);
  endfunction

  // Quiet cycle in a non-sweep state.
  function automatic void add_q(logic s, logic a, logic d, logic [3:0] lvl, logic [1:0] lv,
                                logic g, logic w);
    add(s, a, d, CMD_HOLD, 4'd0, lvl, lv, 1'b0, g, w);
  endfunction

  function automatic void build_table();
    add_q(0,0,0, 0,3, 0,0);
    add_q(1,0,0, 0,3, 0,0);                                   // START from IDLE
    add_sweep(CMD_INIT, 0, 3, -1, N_ROWS);
    add_sweep(CMD_LOAD, 0, 3, -1, N_ROWS);
    add_q(0,1,0, 0,3, 0,0);                                   // ARRIVED -> level 1
    add_sweep(CMD_LOAD, 1, 3, 5, N_ROWS);                     // ARRIVED at row 5 ignored
    add_q(0,1,1, 1,3, 0,0);                                   // DIED+ARRIVED: DIED wins
    add_sweep(CMD_LOAD, 1, 2, -1, N_ROWS);
    add_q(0,1,0, 1,2, 0,0);
    add_sweep(CMD_LOAD, 2, 2, -1, N_ROWS);
    add_q(0,1,0, 2,2, 0,0);
    add_sweep(CMD_LOAD, 3, 2, -1, N_ROWS);
    add_q(0,1,0, 3,2, 0,0);                                   // ARRIVED at LEVEL_MAX
`ifdef SC_LEVELSEQ_WRAP_EN
    add_sweep(CMD_LOAD, 0, 2, -1, N_ROWS);
    add_q(0,0,0, 0,2, 0,0);
    add_q(1,0,0, 0,2, 0,0);                                   // restart from PLAY
`else
    add_q(0,0,1, 3,2, 0,1);                                   // WIN: DIED ignored
    add_q(0,1,0, 3,2, 0,1);
    add_q(1,0,0, 3,2, 0,1);                                   // START leaves WIN
`endif
    add_sweep(CMD_INIT, 0, 3, -1, N_ROWS);
    add_sweep(CMD_LOAD, 0, 3, -1, N_ROWS);
    add_q(0,0,1, 0,3, 0,0);
    add_sweep(CMD_LOAD, 0, 2, -1, N_ROWS);
    add_q(0,0,1, 0,2, 0,0);
    add_sweep(CMD_LOAD, 0, 1, -1, N_ROWS);
    add_q(0,0,1, 0,1, 0,0);                                   // last life
    add_sweep(CMD_INIT, 0, 0, -1, N_ROWS);
    add_q(0,1,0, 0,0, 1,0);                                   // OVER: ARRIVED ignored
    add_q(0,0,0, 0,0, 1,0);
    add_q(1,0,0, 0,0, 1,0);                                   // START leaves OVER
    add_sweep(CMD_INIT, 0, 3, -1, N_ROWS);
    add_sweep(CMD_LOAD, 0, 3, -1, N_ROWS);
    add_q(0,1,0, 0,3, 0,0);
    add_sweep(CMD_LOAD, 1, 3, -1, N_ROWS);
    add_q(0,0,1, 1,3, 0,0);
    add_sweep(CMD_LOAD, 1, 2, -1, N_ROWS);
    add_q(1,0,0, 1,2, 0,0);                                   // START in PLAY = restart
    add_sweep(CMD_INIT, 0, 3, -1, N_ROWS);
    add_sweep(CMD_LOAD, 0, 3, -1, N_ROWS);
    add_q(0,1,0, 0,3, 0,0);
    add_sweep(CMD_LOAD, 1, 3, -1, 7);                         // rows 0..6, reset follows
  endfunction

  // ---------------- scoreboard ----------------
  function automatic logic [OUT_W-1:0] actual_out();
    return {cmd, rowsel, level, lives, busy, gameover, win};
  endfunction

  task automatic check(string name);
    logic [OUT_W-1:0] e, a;
    e = exp_q.pop_front();
    a = actual_out();
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s got cmd=%0d rowsel=%0d level=%0d lives=%0d busy=%0d gameover=%0d win=%0d expected cmd=%0d rowsel=%0d level=%0d lives=%0d busy=%0d gameover=%0d win=%0d",
               name, a[14:13], a[12:9], a[8:5], a[4:3], a[2], a[1], a[0],
               e[14:13], e[12:9], e[8:5], e[4:3], e[2], e[1], e[0]);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(logic s, logic a, logic d);
    start_p = s; arrived_p = a; died_p = d;
  endtask

  initial begin
    build_table();

    drive(0, 0, 0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.push_back(pack_exp(CMD_HOLD, 0, 0, 3, 0, 0, 0));
    check("reset_hold");
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      exp_q.push_back(vecs[i].exp);
      check($sformatf("vec[%0d]", i));
      drive(vecs[i].start, vecs[i].arrived, vecs[i].died);
    end

    // Mid-sweep reset: row 7 of the level-1 LOAD sweep, then async reset.
    @(negedge clk);
    exp_q.push_back(pack_exp(CMD_LOAD, 7, 1, 3, 1, 0, 0));
    check("sweep_row7");
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_back(pack_exp(CMD_HOLD, 0, 0, 3, 0, 0, 0));
    check("async_reset_now");
    n_tests++;
    if (dut.state !== IDLE) begin
      n_fail++;
      $display("FAIL async_reset_state got %0d expected %0d", dut.state, IDLE);
    end
    repeat (2) @(negedge clk);
    exp_q.push_back(pack_exp(CMD_HOLD, 0, 0, 3, 0, 0, 0));
    check("reset_held");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.push_back(pack_exp(CMD_HOLD, 0, 0, 3, 0, 0, 0));
    check("idle_after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
